// File: rtl/dcache_port_responder_pkg.sv
// Request/response payloads for the single-port dcache responder.
package dcache_port_responder_pkg;

  localparam int unsigned INDEX_W = 12;
  localparam int unsigned TAG_W   = 44;
  localparam int unsigned DATA_W  = 64;
  localparam int unsigned BE_W    = DATA_W / 8;

  typedef struct packed {
    logic [INDEX_W-1:0] address_index;
    logic [TAG_W-1:0]   address_tag;
    logic [DATA_W-1:0]  data_wdata;
    logic               data_req;
    logic               data_we;
    logic [BE_W-1:0]    data_be;
    logic               kill_req;
    logic               tag_valid;
  } dcache_req_i_t;

  typedef struct packed {
    logic              data_gnt;
    logic              data_rvalid;
    logic [DATA_W-1:0] data_rdata;
  } dcache_req_o_t;

endpackage

// File: rtl/dcache_port_responder.sv
// Dcache port responder: one outstanding request, index phase then tag phase,
// byte-masked stores and loads returned LATENCY+2 cycles after the grant.
module dcache_port_responder
  import dcache_port_responder_pkg::*;
#(
  parameter int unsigned DEPTH   = 256,
  parameter int unsigned LATENCY = 2
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  dcache_req_i_t req_port_i,
  output dcache_req_o_t req_port_o,
  input  logic          stall_i,
  output logic          busy_o
);

  localparam int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = 4;
  localparam int unsigned PA_W  = TAG_W + INDEX_W;

  typedef enum logic [1:0] {IDLE, TAG, WAIT, RESP} state_t;

  state_t              state_q;
  logic [INDEX_W-1:0]  idx_q;
  logic                we_q;
  logic [BE_W-1:0]     be_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [DATA_W-1:0]   rsp_q;
  logic                rvalid_q;

  logic [DATA_W-1:0]   mem [DEPTH];

  logic                gnt_c;
  logic                tag_hit_c;
  logic                mem_we_c;
  logic [PA_W-1:0]     paddr_c;
  logic [AW-1:0]       word_addr_c;
  logic                unused_paddr;

  assign gnt_c = req_port_i.data_req && (state_q == IDLE) && !stall_i && !rst_i;

  // Byte address is {tag, index}; the word address wraps modulo DEPTH.
  assign paddr_c      = {req_port_i.address_tag, idx_q};
  assign word_addr_c  = paddr_c[AW+2:3];
  assign unused_paddr = ^paddr_c;

  assign tag_hit_c = (state_q == TAG) && req_port_i.tag_valid &&
                     !req_port_i.kill_req && !rst_i;
  assign mem_we_c  = tag_hit_c && we_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      we_q     <= 1'b0;
      be_q     <= '0;
      wdata_q  <= '0;
      cnt_q    <= '0;
      rsp_q    <= '0;
      rvalid_q <= 1'b0;
    end else begin
      rvalid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (gnt_c) begin
            idx_q   <= req_port_i.address_index;
            we_q    <= req_port_i.data_we;
            be_q    <= req_port_i.data_be;
            wdata_q <= req_port_i.data_wdata;
            state_q <= TAG;
          end
        end
        TAG: begin
          if (req_port_i.kill_req) begin
            state_q <= IDLE;
          end else if (req_port_i.tag_valid) begin
            if (we_q) begin
              state_q <= IDLE;
            end else begin
              rsp_q <= mem[word_addr_c];
              if (LATENCY == 0) begin
                state_q  <= RESP;
                rvalid_q <= 1'b1;
              end else begin
                state_q <= WAIT;
                cnt_q   <= CNT_W'(LATENCY - 1);
              end
            end
          end
        end
        WAIT: begin
          if (req_port_i.kill_req) begin
            state_q <= IDLE;
          end else if (cnt_q == '0) begin
            state_q  <= RESP;
            rvalid_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        RESP: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  // Backing array is deliberately not reset.
  always_ff @(posedge clk_i) begin
    if (mem_we_c) begin
      for (int unsigned b = 0; b < BE_W; b++) begin
        if (be_q[b]) begin
          mem[word_addr_c][b*8 +: 8] <= wdata_q[b*8 +: 8];
        end
      end
    end
  end

  assign req_port_o.data_gnt    = gnt_c;
  assign req_port_o.data_rvalid = rvalid_q && !rst_i;
  assign req_port_o.data_rdata  = (rvalid_q && !rst_i) ? rsp_q : '0;
  assign busy_o                 = (state_q != IDLE) && !rst_i;

endmodule

// File: tb/tb_dcache_port_responder.sv
// Directed bench for dcache_port_responder (DEPTH=256, LATENCY=2).
module tb_dcache_port_responder;
  import dcache_port_responder_pkg::*;

  logic          clk = 1'b0;
  logic          rst;
  logic          stall;
  logic          busy;
  dcache_req_i_t req;
  dcache_req_o_t rsp;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  dcache_port_responder #(.DEPTH(256), .LATENCY(2)) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .req_port_i (req),
    .req_port_o (rsp),
    .stall_i    (stall),
    .busy_o     (busy)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input logic we, input int unsigned w, input logic [63:0] d,
                         input logic [7:0] be);
    req.data_req      = 1'b1;
    req.data_we       = we;
    req.address_index = 12'(w * 8);
    req.address_tag   = '0;
    req.data_wdata    = d;
    req.data_be       = be;
    req.kill_req      = 1'b0;
    req.tag_valid     = 1'b0;
  endtask

  task automatic store(input int unsigned w, input logic [63:0] d, input logic [7:0] be);
    set_req(1'b1, w, d, be);
    #1;
    check("st_gnt", 64'(rsp.data_gnt), 64'd1);
    step;
    req.data_req  = 1'b0;
    req.tag_valid = 1'b1;
    #1;
    check("st_busy", 64'(busy), 64'd1);
    check("st_tag_gnt", 64'(rsp.data_gnt), 64'd0);
    step;
    req.tag_valid = 1'b0;
    #1;
    check("st_idle", 64'(busy), 64'd0);
    check("st_no_rvalid", 64'(rsp.data_rvalid), 64'd0);
  endtask

  // Holds data_req through the whole load; expects rvalid 4 cycles after grant
  // and a fresh grant the cycle after rvalid.
  task automatic load(input int unsigned w, input logic [63:0] exp, input int stall_n);
    int n;
    set_req(1'b0, w, 64'd0, 8'h00);
    for (int i = 0; i < stall_n; i++) begin
      stall = 1'b1;
      #1;
      check("stall_gnt", 64'(rsp.data_gnt), 64'd0);
      step;
    end
    stall = 1'b0;
    #1;
    check("ld_gnt", 64'(rsp.data_gnt), 64'd1);
    step;
    req.tag_valid = 1'b1;
    #1;
    check("ld_tag_rvalid", 64'(rsp.data_rvalid), 64'd0);
    step;
    req.tag_valid = 1'b0;
    n = 2;
    while (n < 20 && !rsp.data_rvalid) begin
      check("held_req_gnt", 64'(rsp.data_gnt), 64'd0);
      step;
      n++;
    end
    check("ld_latency", 64'(n), 64'd4);
    check("ld_data", rsp.data_rdata, exp);
    step;
    check("ld_rvalid_drop", 64'(rsp.data_rvalid), 64'd0);
    check("ld_rdata_zero", rsp.data_rdata, 64'd0);
    check("b2b_gnt", 64'(rsp.data_gnt), 64'd1);
    req.data_req = 1'b0;
    #1;
  endtask

  task automatic watch_no_rvalid(input string tag, input int cycles);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < cycles; i++) begin
      if (rsp.data_rvalid) seen = 1'b1;
      step;
    end
    check(tag, 64'(seen), 64'd0);
  endtask

  initial begin
    rst   = 1'b1;
    stall = 1'b0;
    req   = '0;
    req.data_req = 1'b1;
    #1;
    check("rst_gnt", 64'(rsp.data_gnt), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    step;
    step;
    check("rst_rvalid", 64'(rsp.data_rvalid), 64'd0);
    check("rst_rdata", rsp.data_rdata, 64'd0);
    check("rst_busy2", 64'(busy), 64'd0);
    rst = 1'b0;
    req.data_req = 1'b0;
    #1;

    // Full store then load of word 5.
    store(5, 64'h1122334455667788, 8'hFF);
    load(5, 64'h1122334455667788, 0);

    // Low-half byte-masked merge, load right after the store.
    store(5, 64'hAAAAAAAABBBBBBBB, 8'h0F);
    load(5, 64'h11223344BBBBBBBB, 0);

    // Stall for 3 cycles, then load word 256+7 which wraps onto word 7.
    store(7, 64'h0123456789ABCDEF, 8'hFF);
    load(263, 64'h0123456789ABCDEF, 3);

    // Killed load: no rvalid, immediate re-grant.
    set_req(1'b0, 5, 64'd0, 8'h00);
    #1;
    check("kill_ld_gnt", 64'(rsp.data_gnt), 64'd1);
    step;
    req.tag_valid = 1'b1;
    req.kill_req  = 1'b1;
    step;
    req.tag_valid = 1'b0;
    req.kill_req  = 1'b0;
    #1;
    check("kill_idle", 64'(busy), 64'd0);
    check("kill_regnt", 64'(rsp.data_gnt), 64'd1);
    req.data_req = 1'b0;
    #1;
    watch_no_rvalid("kill_no_rvalid", 6);

    // Killed store must leave word 5 untouched.
    set_req(1'b1, 5, 64'hDEADDEADDEADDEAD, 8'hFF);
    #1;
    check("kill_st_gnt", 64'(rsp.data_gnt), 64'd1);
    step;
    req.data_req  = 1'b0;
    req.tag_valid = 1'b1;
    req.kill_req  = 1'b1;
    step;
    req.tag_valid = 1'b0;
    req.kill_req  = 1'b0;
    #1;
    load(5, 64'h11223344BBBBBBBB, 0);

    // Reset pulsed while waiting: load aborted, next load completes.
    set_req(1'b0, 7, 64'd0, 8'h00);
    #1;
    check("rstw_gnt", 64'(rsp.data_gnt), 64'd1);
    step;
    req.data_req  = 1'b0;
    req.tag_valid = 1'b1;
    step;
    req.tag_valid = 1'b0;
    #1;
    check("rstw_busy_wait", 64'(busy), 64'd1);
    rst = 1'b1;
    #1;
    check("rstw_busy_in_rst", 64'(busy), 64'd0);
    step;
    rst = 1'b0;
    #1;
    check("rstw_busy_after", 64'(busy), 64'd0);
    watch_no_rvalid("rstw_no_rvalid", 6);
    load(7, 64'h0123456789ABCDEF, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
